// File: rtl/sram_arbiter_if.sv
// Bus bundle between the I/D requesters, the arbiter and a single-port SRAM.
// master = requesters plus SRAM data return; slave = the arbiter.
interface sram_arbiter_if #(
    parameter int unsigned AWIDTH = 12
);
    logic              I_REQ;
    logic [AWIDTH-1:0] I_ADDR;
    logic              I_ACK;
    logic              I_RVALID;
    logic [31:0]       I_RDATA;

    logic              D_REQ;
    logic              D_WE;
    logic [3:0]        D_BE;
    logic [AWIDTH-1:0] D_ADDR;
    logic [31:0]       D_WDATA;
    logic              D_ACK;
    logic              D_RVALID;
    logic [31:0]       D_RDATA;

    logic              M_CSN;
    logic              M_WEN;
    logic [AWIDTH-1:0] M_ADDR;
    logic [3:0]        M_BE;
    logic [31:0]       M_DI;
    logic [31:0]       M_DOUT;

    modport master (
        output I_REQ, I_ADDR, D_REQ, D_WE, D_BE, D_ADDR, D_WDATA, M_DOUT,
        input  I_ACK, I_RVALID, I_RDATA, D_ACK, D_RVALID, D_RDATA,
        input  M_CSN, M_WEN, M_ADDR, M_BE, M_DI
    );

    modport slave (
        input  I_REQ, I_ADDR, D_REQ, D_WE, D_BE, D_ADDR, D_WDATA, M_DOUT,
        output I_ACK, I_RVALID, I_RDATA, D_ACK, D_RVALID, D_RDATA,
        output M_CSN, M_WEN, M_ADDR, M_BE, M_DI
    );
endinterface

// File: rtl/sram_arbiter.sv
// Arbitrates an instruction read port and a data read/write port onto one SRAM.
// Default: D priority with I starvation guard; define SRAM_ARB_RR_EN for round-robin.
module sram_arbiter #(
    parameter int unsigned AWIDTH     = 12,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          CLK,
    input  logic          RSTN,
    sram_arbiter_if.slave bus
);
    localparam logic [AWIDTH-1:0] ADDR_ZERO = '0;

    logic grant_i;
    logic grant_d;
    logic rd_accept;
    logic rd_pend;
    logic rd_owner_i;

`ifdef SRAM_ARB_RR_EN
    logic last_i;
`else
    localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);
    logic [CW-1:0] starve_cnt;
`endif

    // Grant selection; nothing is granted while reset is asserted.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (RSTN) begin
            if (bus.I_REQ && bus.D_REQ) begin
`ifdef SRAM_ARB_RR_EN
                grant_i = ~last_i;
`else
                grant_i = (starve_cnt == STARVE_LIM);
`endif
                grant_d = ~grant_i;
            end else begin
                grant_i = bus.I_REQ;
                grant_d = bus.D_REQ;
            end
        end
    end

    // SRAM command mux, idle values when nobody is granted.
    always_comb begin
        bus.M_CSN  = 1'b1;
        bus.M_WEN  = 1'b1;
        bus.M_ADDR = ADDR_ZERO;
        bus.M_BE   = 4'h0;
        bus.M_DI   = 32'h0;
        if (grant_i) begin
            bus.M_CSN  = 1'b0;
            bus.M_ADDR = bus.I_ADDR;
            bus.M_BE   = 4'hF;
        end else if (grant_d) begin
            bus.M_CSN  = 1'b0;
            bus.M_WEN  = ~bus.D_WE;
            bus.M_ADDR = bus.D_ADDR;
            bus.M_BE   = bus.D_BE;
            bus.M_DI   = bus.D_WDATA;
        end
    end

    assign bus.I_ACK  = grant_i;
    assign bus.D_ACK  = grant_d;
    assign rd_accept  = grant_i | (grant_d & ~bus.D_WE);

    // Read-return tracking and arbitration history.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rd_pend    <= 1'b0;
            rd_owner_i <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            last_i     <= 1'b0;
`else
            starve_cnt <= '0;
`endif
        end else begin
            rd_pend    <= rd_accept;
            rd_owner_i <= grant_i;
`ifdef SRAM_ARB_RR_EN
            if (grant_i || grant_d) begin
                last_i <= grant_i;
            end
`else
            if (bus.I_REQ && !grant_i) begin
                if (starve_cnt != STARVE_LIM) begin
                    starve_cnt <= starve_cnt + CW'(1);
                end
            end else begin
                starve_cnt <= '0;
            end
`endif
        end
    end

    // SRAM data is presented in the cycle after the read was accepted.
    assign bus.I_RVALID = rd_pend & rd_owner_i;
    assign bus.D_RVALID = rd_pend & ~rd_owner_i;
    assign bus.I_RDATA  = bus.I_RVALID ? bus.M_DOUT : 32'h0;
    assign bus.D_RDATA  = bus.D_RVALID ? bus.M_DOUT : 32'h0;
endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: SRAM model, reference model, directed scenarios.
module tb_sram_arbiter;
    localparam int unsigned AW = 12;
    localparam int unsigned SM = 4;
    localparam int unsigned DEPTH = 1 << AW;

    logic CLK = 1'b0;
    logic RSTN = 1'b0;

    sram_arbiter_if #(.AWIDTH(AW)) bus ();

    sram_arbiter #(.AWIDTH(AW), .STARVE_MAX(SM)) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus.slave)
    );

    always #5 CLK = ~CLK;

    int n_vec  = 0;
    int n_fail = 0;

    function automatic logic [31:0] init_val(input int a);
        if (a == 'h010) return 32'h0000_0013;
        if (a == 'h020) return 32'h1111_1111;
        if (a < 4) return 32'hA000_0000 + 32'(a);
        return 32'h0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic chk_s(input string nm, input string act, input string exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %s expected %s", nm, act, exp);
        end
    endtask

    // Synchronous single-port SRAM; reloads its image while reset is held.
    logic [31:0] mem [DEPTH];
    always @(posedge CLK) begin
        if (!RSTN) begin
            for (int a = 0; a < int'(DEPTH); a++) mem[a] <= init_val(a);
        end else if (!bus.M_CSN) begin
            if (!bus.M_WEN) mem[bus.M_ADDR] <= merge(mem[bus.M_ADDR], bus.M_DI, bus.M_BE);
            else            bus.M_DOUT <= mem[bus.M_ADDR];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [DEPTH];
    bit          m_pend, m_own_i, m_last_i;
    logic [31:0] m_data;
    int          m_wait;

    // Observation logs for the scenario-level literal checks
    bit          log_g = 0, log_rv = 0;
    string       dut_g = "", mdl_g = "", rv_s = "";
    int          i_rv_cnt = 0, d_rv_cnt = 0;
    logic [31:0] last_i_data = 0, last_d_data = 0;
    logic [31:0] dq [$];

    always @(negedge CLK) begin
        bit          gi, gd;
        logic [31:0] e_addr, e_be, e_di;
        bit          e_csn, e_wen;
        if (!RSTN) begin
            chk("rst_csn", 32'(bus.M_CSN), 1);
            chk("rst_wen", 32'(bus.M_WEN), 1);
            chk("rst_iack", 32'(bus.I_ACK), 0);
            chk("rst_dack", 32'(bus.D_ACK), 0);
            chk("rst_irv", 32'(bus.I_RVALID), 0);
            chk("rst_drv", 32'(bus.D_RVALID), 0);
            chk("rst_irdata", bus.I_RDATA, 0);
            chk("rst_drdata", bus.D_RDATA, 0);
            m_pend = 0; m_own_i = 0; m_last_i = 0; m_wait = 0;
            for (int a = 0; a < int'(DEPTH); a++) ref_mem[a] = init_val(a);
        end else begin
            gi = 0; gd = 0;
            if (bus.I_REQ && bus.D_REQ) begin
`ifdef SRAM_ARB_RR_EN
                gi = !m_last_i;
`else
                gi = (m_wait >= int'(SM));
`endif
                gd = !gi;
            end else begin
                gi = bus.I_REQ;
                gd = bus.D_REQ;
            end
            e_csn = !(gi || gd);
            e_wen = !(gd && bus.D_WE);
            e_addr = gi ? 32'(bus.I_ADDR) : gd ? 32'(bus.D_ADDR) : 0;
            e_be   = gi ? 32'hF : gd ? 32'(bus.D_BE) : 0;
            e_di   = gd ? bus.D_WDATA : 0;
            chk("i_ack", 32'(bus.I_ACK), 32'(gi));
            chk("d_ack", 32'(bus.D_ACK), 32'(gd));
            chk("m_csn", 32'(bus.M_CSN), 32'(e_csn));
            chk("m_wen", 32'(bus.M_WEN), 32'(e_wen));
            chk("m_addr", 32'(bus.M_ADDR), e_addr);
            chk("m_be", 32'(bus.M_BE), e_be);
            chk("m_di", bus.M_DI, e_di);
            chk("i_rvalid", 32'(bus.I_RVALID), 32'(m_pend && m_own_i));
            chk("d_rvalid", 32'(bus.D_RVALID), 32'(m_pend && !m_own_i));
            chk("i_rdata", bus.I_RDATA, (m_pend && m_own_i) ? m_data : 0);
            chk("d_rdata", bus.D_RDATA, (m_pend && !m_own_i) ? m_data : 0);

            if (log_g) begin
                dut_g = {dut_g, bus.I_ACK ? "I" : bus.D_ACK ? "D" : "-"};
                mdl_g = {mdl_g, gi ? "I" : gd ? "D" : "-"};
            end
            if (log_rv) begin
                rv_s = {rv_s, bus.D_RVALID ? "1" : "0"};
                if (bus.D_RVALID) dq.push_back(bus.D_RDATA);
            end

            // advance model by one cycle
            m_pend  = gi || (gd && !bus.D_WE);
            m_own_i = gi;
            if (gi) m_data = ref_mem[bus.I_ADDR];
            else if (gd) m_data = ref_mem[bus.D_ADDR];
            if (gd && bus.D_WE)
                ref_mem[bus.D_ADDR] = merge(ref_mem[bus.D_ADDR], bus.D_WDATA, bus.D_BE);
            m_wait = (bus.I_REQ && !gi) ? m_wait + 1 : 0;
            if (gi || gd) m_last_i = gi;
        end
        if (bus.I_RVALID) begin i_rv_cnt++; last_i_data = bus.I_RDATA; end
        if (bus.D_RVALID) begin d_rv_cnt++; last_d_data = bus.D_RDATA; end
    end

    task automatic cyc(input logic ir, input logic [AW-1:0] ia, input logic dr, input logic we,
                       input logic [3:0] be, input logic [AW-1:0] da, input logic [31:0] wd);
        bus.I_REQ = ir; bus.I_ADDR = ia;
        bus.D_REQ = dr; bus.D_WE = we; bus.D_BE = be; bus.D_ADDR = da; bus.D_WDATA = wd;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 4'h0, 0, 0);
    endtask

    initial begin
        int c0;
        string exp_g;
        // Reset held with both ports requesting
        RSTN = 1'b0;
        cyc(1, 12'h010, 1, 1, 4'hF, 12'h020, 32'hFFFF_FFFF);
        cyc(1, 12'h010, 1, 0, 4'hF, 12'h020, 32'h0);
        RSTN = 1'b1;

        // Single I read accepted on the first edge after release
        c0 = i_rv_cnt;
        cyc(1, 12'h010, 0, 0, 4'h0, 0, 0);
        idle();
        chk("i_read_rv_count", 32'(i_rv_cnt - c0), 1);
        chk("i_read_data", last_i_data, 32'h0000_0013);

        // Partial write then read back; the write yields no RVALID
        c0 = d_rv_cnt;
        cyc(0, 0, 1, 1, 4'b0011, 12'h020, 32'hAABB_CCDD);
        cyc(0, 0, 1, 0, 4'h0, 12'h020, 0);
        idle();
        chk("d_wr_rd_rv_count", 32'(d_rv_cnt - c0), 1);
        chk("d_wr_rd_data", last_d_data, 32'h1111_CCDD);

        // Both ports requesting for six cycles
        log_g = 1;
        for (int k = 0; k < 6; k++) cyc(1, 12'h010, 1, 0, 4'h0, 12'h001, 0);
        log_g = 0;
        idle();
`ifdef SRAM_ARB_RR_EN
        exp_g = "IDIDID";
`else
        exp_g = "DDDDID";
`endif
        chk_s("grant_seq_dut", dut_g, exp_g);
        chk_s("grant_seq_model", mdl_g, exp_g);

        // Reset asserted right after an accepted I read drops the return
        c0 = i_rv_cnt;
        cyc(1, 12'h010, 0, 0, 4'h0, 0, 0);
        RSTN = 1'b0;
        cyc(1, 12'h010, 1, 0, 4'h0, 12'h003, 0);
        RSTN = 1'b1;
        idle();
        idle();
        chk("rst_drop_rv_count", 32'(i_rv_cnt - c0), 0);

        // Back-to-back D reads
        log_rv = 1;
        for (int k = 0; k < 4; k++) cyc(0, 0, 1, 0, 4'h0, 12'(k), 0);
        idle();
        idle();
        log_rv = 0;
        chk_s("d_burst_rvalid", rv_s, "011110");
        chk("d_burst_count", 32'(dq.size()), 4);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] got;
            got = (k < dq.size()) ? dq[k] : 32'hDEAD_0000;
            chk("d_burst_data", got, 32'hA000_0000 + 32'(k));
        end

        // Write/read mix with contention on the same word
        cyc(1, 12'h005, 1, 1, 4'hF, 12'h005, 32'hDEAD_BEEF);
        cyc(1, 12'h005, 1, 0, 4'h0, 12'h005, 0);
        cyc(0, 0, 1, 1, 4'b1000, 12'h005, 32'h5500_0000);
        cyc(1, 12'h005, 1, 0, 4'h0, 12'h002, 0);
        cyc(1, 12'h005, 0, 0, 4'h0, 0, 0);
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter AWIDTH, default 12, SRAM word-address width.
REQ-002 SHALL have parameter STARVE_MAX, default 4, max consecutive cycles the I port may be denied while requesting.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port RSTN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port I_REQ  input  1  instruction-port read request.
REQ-006 SHALL have port I_ADDR  input  AWIDTH  instruction-port word address.
REQ-007 SHALL have port I_ACK  output  1  instruction request accepted this cycle.
REQ-008 SHALL have port I_RVALID  output  1  instruction read data valid.
REQ-009 SHALL have port I_RDATA  output  32  instruction read data.
REQ-010 SHALL have port D_REQ  input  1  data-port request.
REQ-011 SHALL have port D_WE  input  1  data-port write, 1=write, 0=read.
REQ-012 SHALL have port D_BE  input  4  data-port byte enables for writes.
REQ-013 SHALL have port D_ADDR  input  AWIDTH  data-port word address.
REQ-014 SHALL have port D_WDATA  input  32  data-port write data.
REQ-015 SHALL have port D_ACK  output  1  data request accepted this cycle.
REQ-016 SHALL have port D_RVALID  output  1  data read data valid.
REQ-017 SHALL have port D_RDATA  output  32  data read data.
REQ-018 SHALL have port M_CSN  output  1  SRAM chip select, active-low.
REQ-019 SHALL have port M_WEN  output  1  SRAM write enable, 1=read, 0=write.
REQ-020 SHALL have port M_ADDR  output  AWIDTH  SRAM address.
REQ-021 SHALL have port M_BE  output  4  SRAM byte enables.
REQ-022 SHALL have port M_DI  output  32  SRAM write data.
REQ-023 SHALL have port M_DOUT  input  32  SRAM read data, valid after the posedge following a read.

Function
REQ-024 SHALL grant at most one requester per cycle; grant, ACK and M_* command are combinational from current REQs and registered arbitration state.
REQ-025 SHALL, with no REQ, drive M_CSN=1, M_WEN=1, M_ADDR/M_BE/M_DI=0, both ACKs 0.
REQ-026 SHALL for an I grant drive M_CSN=0, M_WEN=1, M_ADDR=I_ADDR, M_BE=4'hF, M_DI=0, I_ACK=1.
REQ-027 SHALL for a D grant drive M_CSN=0, M_WEN=~D_WE, M_ADDR=D_ADDR, M_BE=D_BE, M_DI=D_WDATA, D_ACK=1.
REQ-028 SHALL register a pending-read flag and owner at each accepted read; next cycle assert owner's RVALID for exactly one cycle with RDATA=M_DOUT.
REQ-029 SHALL drive RDATA=0 when the corresponding RVALID is 0; writes produce no RVALID.
REQ-030 SHALL sustain one accepted request per cycle (back-to-back reads, read-after-write, write-after-read) with no bubble.
REQ-031 SHALL, default policy, grant D over I when both request, except when starve counter equals STARVE_MAX, then grant I.
REQ-032 SHALL increment starve counter each cycle I_REQ=1 and I not granted, clear it on I grant or I_REQ=0; counter saturates at STARVE_MAX.
REQ-033 SHALL keep a requester's REQ and command stable until its ACK; arbiter does not latch unacknowledged requests.

Reset
REQ-034 SHALL while RSTN=0 force M_CSN=1, M_WEN=1, all ACKs 0, RVALIDs 0, RDATAs 0, regardless of REQs.
REQ-035 SHALL clear pending-read flag, owner, starve counter and last-grant pointer asynchronously; a read in flight at reset is dropped with no RVALID after release.
REQ-036 SHALL accept requests on the first posedge after RSTN deasserts.

Configuration
REQ-037 SHALL, with SRAM_ARB_RR_EN defined, replace REQ-031/032 with round-robin: on conflict grant the port not granted last; last-grant pointer resets to D (I wins first conflict); no starve counter.
REQ-038 SHALL, without SRAM_ARB_RR_EN, use fixed D priority with starvation counter per REQ-031/032.

Verification
REQ-039 SHALL cover: I read 0x010 alone, SRAM[0x010]=0x00000013 -> I_ACK same cycle, I_RVALID next cycle, I_RDATA=0x00000013.
REQ-040 SHALL cover: D write 0x020 data 0xAABBCCDD BE=4'b0011 over 0x11111111, then D read 0x020 -> D_RDATA=0x1111CCDD, no RVALID for the write.
REQ-041 SHALL cover: I_REQ and D_REQ held 6 cycles, default build, STARVE_MAX=4 -> grants D,D,D,D,I,D.
REQ-042 SHALL cover: same stimulus with SRAM_ARB_RR_EN -> grants I,D,I,D,I,D.
REQ-043 SHALL cover: RSTN low one cycle after accepted I read -> I_RVALID never asserts, M_CSN=1 during reset.
REQ-044 SHALL cover: D reads 0x000..0x003 on consecutive cycles -> four consecutive D_RVALID cycles with matching data.
